// File: rtl/ibex_pkg.sv
// Shared types and helpers for the instruction prefetch path.
package ibex_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_GNT
    } prefetch_ctrl_state_e;

    localparam logic [31:0] FETCH_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_prefetch_ctrl_if.sv
// Core, fetch-FIFO and instruction-memory signals of the prefetch controller.
interface ibex_prefetch_ctrl_if;

    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        busy_o;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic        fifo_ready_i;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    // The prefetch controller drives the memory bus and the FIFO.
    modport master (
        input  req_i, branch_i, addr_i, fifo_ready_i,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output busy_o, fifo_clear_o, fifo_valid_o, fifo_addr_o,
        output fifo_rdata_o, fifo_err_o, instr_req_o, instr_addr_o
    );

    modport slave (
        output req_i, branch_i, addr_i, fifo_ready_i,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  busy_o, fifo_clear_o, fifo_valid_o, fifo_addr_o,
        input  fifo_rdata_o, fifo_err_o, instr_req_o, instr_addr_o
    );

endinterface

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction prefetch controller: issues word fetches, tracks outstanding
// requests and drops responses that belong to the pre-branch stream.
module ibex_prefetch_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ibex_prefetch_ctrl_if.master bus
);

    localparam int unsigned      CNT_W   = $clog2(NUM_REQS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_REQS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    prefetch_ctrl_state_e state_reg;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CNT_W-1:0]     dcnt_reg, dcnt_next;
    logic [31:0]          fetch_addr_reg, fetch_addr_next;
    logic [31:0]          branch_addr;
    logic                 req_out;
    logic                 gnt_fire;

    assign branch_addr = word_align(bus.addr_i);

    // A branch overrides a full FIFO because the clear frees every slot.
    always_comb begin
        req_out = 1'b0;
        if (state_reg == WAIT_GNT) begin
            req_out = 1'b1;
        end else if (bus.req_i && (cnt_reg < MAX_CNT) && (bus.fifo_ready_i || bus.branch_i)) begin
            req_out = 1'b1;
        end
    end

    assign gnt_fire = req_out && bus.instr_gnt_i;

    always_comb begin
        cnt_next = cnt_reg;
        if (gnt_fire) begin
            cnt_next = cnt_next + ONE;
        end
        if (bus.instr_rvalid_i && (cnt_reg != '0)) begin
            cnt_next = cnt_next - ONE;
        end
    end

    // The request granted in a branch cycle already targets the new stream.
    always_comb begin
        dcnt_next = dcnt_reg;
        if (bus.branch_i) begin
            dcnt_next = cnt_next - (gnt_fire ? ONE : '0);
        end else if (bus.instr_rvalid_i && (dcnt_reg != '0)) begin
            dcnt_next = dcnt_reg - ONE;
        end
    end

    always_comb begin
        fetch_addr_next = fetch_addr_reg;
        if (gnt_fire) begin
            fetch_addr_next = bus.instr_addr_o + FETCH_STEP;
        end else if (bus.branch_i) begin
            fetch_addr_next = branch_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            dcnt_reg       <= '0;
            fetch_addr_reg <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            dcnt_reg       <= dcnt_next;
            fetch_addr_reg <= fetch_addr_next;
            unique case (state_reg)
                IDLE:     if (req_out && !bus.instr_gnt_i) state_reg <= WAIT_GNT;
                WAIT_GNT: if (bus.instr_gnt_i)             state_reg <= IDLE;
                default:                                   state_reg <= IDLE;
            endcase
        end
    end

    assign bus.instr_req_o  = req_out;
    assign bus.instr_addr_o = bus.branch_i ? branch_addr : fetch_addr_reg;
    assign bus.busy_o       = (cnt_reg != '0) || req_out;
    assign bus.fifo_clear_o = bus.branch_i;
    assign bus.fifo_addr_o  = bus.addr_i;
    assign bus.fifo_valid_o = bus.instr_rvalid_i && (dcnt_reg == '0);
    assign bus.fifo_rdata_o = bus.instr_rdata_i;
    assign bus.fifo_err_o   = bus.instr_err_i;

    // A response with nothing outstanding means the memory broke protocol.
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.instr_rvalid_i && (cnt_reg == '0)));

    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        (cnt_reg <= MAX_CNT) && (dcnt_reg <= cnt_reg));

endmodule

// File: doc/ibex_prefetch_ctrl.md
IBEX_PREFETCH_CTRL -- requirements
Module: ibex_prefetch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQS, default 2, meaning the maximum number of outstanding instruction-memory requests (legal range 1..4).
REQ-002 The block SHALL have these ports, each listed as name  direction  width  meaning:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  core requests instruction fetching.
- branch_i  in  1  redirect fetching to addr_i.
- addr_i  in  32  branch target, halfword aligned.
- busy_o  out  1  requests pending or outstanding.
- fifo_clear_o  out  1  clears the downstream fetch FIFO.
- fifo_valid_o  out  1  response word valid toward the FIFO.
- fifo_ready_i  in  1  FIFO has space for NUM_REQS words.
- fifo_addr_o  out  32  start address loaded by the FIFO on clear.
- fifo_rdata_o  out  32  response word.
- fifo_err_o  out  1  response bus error.
- instr_req_o  out  1  memory request.
- instr_gnt_i  in  1  memory grant.
- instr_addr_o  out  32  word-aligned request address.
- instr_rvalid_i  in  1  memory response valid.
- instr_rdata_i  in  32  memory response data.
- instr_err_i  in  1  memory response error.
REQ-003 The block SHALL use one clock domain, clk_i; reset SHALL be synchronous and active-high on rst_i.

Function
REQ-004 The FSM SHALL have two states:
- IDLE: no un-granted request is pending.
- WAIT_GNT: instr_req_o is held awaiting instr_gnt_i.
REQ-005 In IDLE, instr_req_o SHALL be 1 when req_i=1 & cnt<NUM_REQS & (fifo_ready_i | branch_i); cnt is the outstanding counter, width clog2(NUM_REQS+1).
REQ-006 In IDLE, if instr_req_o=1 and instr_gnt_i=0, the FSM SHALL go to WAIT_GNT; otherwise it SHALL stay in IDLE.
REQ-007 In WAIT_GNT:
- instr_req_o SHALL be 1 regardless of req_i and fifo_ready_i.
- instr_addr_o SHALL be stable until grant, except on branch_i.
- The FSM SHALL return to IDLE on instr_gnt_i.
REQ-008 instr_addr_o SHALL equal fetch_addr, a 32-bit register, except in a branch_i cycle, where it SHALL equal {addr_i[31:2],2'b00}.
REQ-009 fetch_addr updates:
- On grant: issued address + 4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
- On branch_i without grant: {addr_i[31:2],2'b00}.
REQ-010 fifo_clear_o SHALL equal branch_i combinationally, and fifo_addr_o SHALL equal addr_i.
REQ-011 The counters SHALL update as follows:
- cnt_next = cnt + (instr_req_o & instr_gnt_i) - instr_rvalid_i.
- cnt SHALL never exceed NUM_REQS or underflow.
- A response arriving with cnt=0 is a protocol violation, reported by assertion.
REQ-012 The discard counter dcnt SHALL work as follows:
- On branch_i, dcnt_next = cnt_next - (instr_req_o & instr_gnt_i); the grant of the branch-cycle request is kept.
- Otherwise dcnt SHALL decrement on each instr_rvalid_i while dcnt>0.
REQ-013 fifo_valid_o SHALL be instr_rvalid_i & (dcnt==0), with zero latency.
REQ-014 fifo_rdata_o and fifo_err_o SHALL pass instr_rdata_i and instr_err_i through unregistered.
REQ-015 A response in the same cycle as branch_i SHALL be forwarded and discarded by the FIFO clear; it SHALL NOT be counted in dcnt.
REQ-016 A branch in the same cycle as a grant SHALL count the granted request as a new-target request: it is not discarded and the new target is issued.
REQ-017 busy_o SHALL be (cnt!=0) | instr_req_o.

Reset
REQ-018 While rst_i=1 at a clk_i edge:
- state SHALL go to IDLE.
- cnt, dcnt and fetch_addr SHALL go to 0.
REQ-019 In the cycle after reset:
- instr_req_o=0, fifo_valid_o=0 and busy_o=0, given req_i=0 and instr_rvalid_i=0.
- Responses to pre-reset requests are not tracked; the memory is reset together with the block.

Structure
REQ-020 The state enum prefetch_ctrl_state_e {IDLE, WAIT_GNT} SHALL live in ibex_pkg.
REQ-021 NUM_REQS SHALL be passed down from ibex_prefetch_buffer, which instantiates this block next to ibex_fetch_fifo.
REQ-022 The block SHALL be a single module with no sub-module.

Verification
REQ-023 Branch to 0x0000_1002 with req_i=1 and gnt=1 -> instr_addr_o=0x0000_1000, fifo_clear_o=1, fifo_addr_o=0x0000_1002; next request address is 0x0000_1004.
REQ-024 Two grants, then branch, then two rvalid -> both responses dropped (fifo_valid_o=0); the third rvalid is forwarded with its data.
REQ-025 gnt held low for 3 cycles -> instr_req_o and instr_addr_o stable for 4 cycles; grant on the 4th cycle returns the FSM to IDLE.
REQ-026 NUM_REQS=2 with 2 outstanding -> instr_req_o=0 until rvalid; fifo_ready_i=0 -> no new request is issued.
REQ-027 fetch_addr=0xFFFF_FFFC granted -> next instr_addr_o=0x0000_0000; rst_i mid-WAIT_GNT -> IDLE with cnt=0 next cycle.
